// File: rtl/ofifo_pkg.sv
// -----------------------------------------------------------------------------
// ofifo_pkg
// Constants and helpers shared by the output FIFO (ofifo) and mac_array. The
// array and the buffer both take their default geometry from here, so the
// two cannot disagree on column count or psum width.
// -----------------------------------------------------------------------------
package ofifo_pkg;

  // Default geometry shared with mac_array.
  localparam int OFIFO_COL_DEF     = 8;
  localparam int OFIFO_PSUM_BW_DEF = 16;
  localparam int OFIFO_DEPTH_DEF   = 64;

  // Pointer width for a FIFO of the given depth. The extra MSB tells a full
  // FIFO apart from an empty one when the index bits are equal.
  function automatic int ofifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OFIFO_PTR_W = ofifo_ptr_w(OFIFO_DEPTH_DEF);

  // LSB position of column c's slice on a packed psum bus.
  function automatic int ofifo_slice_lo(input int c, input int bw);
    return c * bw;
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// -----------------------------------------------------------------------------
// ofifo_col
// Single-column first-word-fall-through FIFO used by ofifo.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears pointers and overflow)
//   i_wr       push i_data this edge
//   i_rd       pop the head entry this edge (ignored when empty)
//   i_data     psum to store
//   o_data     head entry, zero when empty
//   o_empty    no entries held
//   o_full     depth entries held
//   o_overflow sticky: a push arrived while full with no same-edge pop
// -----------------------------------------------------------------------------
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int psum_bw = OFIFO_PSUM_BW_DEF,
  parameter int depth   = OFIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [psum_bw-1:0] i_data,
  output logic [psum_bw-1:0] o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow
);

  localparam int PTR_W = ofifo_ptr_w(depth);
  localparam int IDX_W = PTR_W - 1;

  logic [psum_bw-1:0] r_mem [depth];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic               r_overflow;
  logic               w_push;
  logic               w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]) &&
                   (r_wptr[IDX_W] != r_rptr[IDX_W]);

  // A full column still accepts a write when a pop frees the head slot on
  // the same edge; occupancy is then unchanged.
  assign w_pop  = i_rd & ~o_empty;
  assign w_push = i_wr & (~o_full | w_pop);

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so pointer and flag updates never race each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      if (i_wr && !w_push)
        r_overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers alone define
  // what is valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[IDX_W-1:0]] <= i_data;
  end

  // Gating on empty makes the output read zero after reset rather than
  // whatever the array happens to hold.
  assign o_data     = o_empty ? {psum_bw{1'b0}} : r_mem[r_rptr[IDX_W-1:0]];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ofifo.sv
// -----------------------------------------------------------------------------
// ofifo
// Output collection buffer behind mac_array. Each column's psum is captured in
// its own FIFO when that column's valid strobe pulses; because columns arrive
// skewed by one cycle each, a row is only released once every column holds at
// least one entry. Reads pop one whole row, first-word-fall-through.
//
// Build option: define OFIFO_RELU_EN to clamp negative psums to zero on the
// read path (stored data stays raw; flags and pointers are unaffected).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in          psum bus, column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr          per-column write strobe (mac_array valid)
//   rd          pop one complete row (ignored while o_valid=0)
//   out         head row, same column layout as in
//   o_valid     every column non-empty
//   o_full      any column full
//   o_overflow  sticky: a write to a full column was dropped
// -----------------------------------------------------------------------------
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = OFIFO_COL_DEF,
  parameter int psum_bw = OFIFO_PSUM_BW_DEF,
  parameter int depth   = OFIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_overflow
);

  logic [col-1:0] w_empty;
  logic [col-1:0] w_full;
  logic [col-1:0] w_ovf;
  logic           w_pop;

  // Flags come only from registered pointers, so rd/wr never reach them
  // combinationally.
  assign o_valid    = ~|w_empty;
  assign o_full     = |w_full;
  assign o_overflow = |w_ovf;

  // A row pop moves every column together, and only when a whole row exists.
  assign w_pop = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    localparam int LO = ofifo_slice_lo(c, psum_bw);

    logic [psum_bw-1:0] w_head;

    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk        (clk),
      .rst_n      (reset),
      .i_wr       (wr[c]),
      .i_rd       (w_pop),
      .i_data     (in[LO +: psum_bw]),
      .o_data     (w_head),
      .o_empty    (w_empty[c]),
      .o_full     (w_full[c]),
      .o_overflow (w_ovf[c])
    );

`ifdef OFIFO_RELU_EN
    assign out[LO +: psum_bw] = w_head[psum_bw-1] ? {psum_bw{1'b0}} : w_head;
`else
    assign out[LO +: psum_bw] = w_head;
`endif
  end

endmodule

// File: tb/tb_ofifo.sv
// -----------------------------------------------------------------------------
// tb_ofifo
// Self-checking bench for ofifo. A queue-per-column model tracks what the
// buffer should hold; directed steps cover reset, skewed fill, full/overflow,
// simultaneous read/write on full, reads while not valid and the ReLU option,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int W     = COL * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   tb_in;
  logic [COL-1:0] tb_wr;
  logic           tb_rd;
  logic [W-1:0]   tb_out;
  logic           tb_valid;
  logic           tb_full;
  logic           tb_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per column plus a sticky overflow bit.
  logic [BW-1:0] q [COL][$];
  logic          m_ovf;

  ofifo #(
    .col     (COL),
    .psum_bw (BW),
    .depth   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (tb_in),
    .wr         (tb_wr),
    .rd         (tb_rd),
    .out        (tb_out),
    .o_valid    (tb_valid),
    .o_full     (tb_full),
    .o_overflow (tb_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef OFIFO_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [W-1:0] relu_row(input logic [W-1:0] r);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = relu(r[c*BW +: BW]);
    return v;
  endfunction

  function automatic logic model_valid();
    for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < COL; c++) if (q[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v = '0;
    for (int c = 0; c < COL; c++)
      if (q[c].size() > 0) v[c*BW +: BW] = relu(q[c][0]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"},    W'(tb_valid), W'(model_valid()));
    check({tag, ".full"},     W'(tb_full),  W'(model_full()));
    check({tag, ".overflow"}, W'(tb_ovf),   W'(m_ovf));
    check({tag, ".out"},      tb_out,       model_out());
  endtask

  function automatic void model_clear();
    for (int c = 0; c < COL; c++) q[c].delete();
    m_ovf = 1'b0;
  endfunction

  // One clock: starts just after a falling edge, ends at the next one.
  task automatic step(input logic [COL-1:0] wm, input logic [W-1:0] wd, input logic r,
                      input string tag);
    logic pop;
    tb_wr = wm;
    tb_in = wd;
    tb_rd = r;
    @(posedge clk);
    pop = r && model_valid();
    for (int c = 0; c < COL; c++) begin
      if (wm[c]) begin
        if (q[c].size() < DEPTH || pop) q[c].push_back(wd[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
    if (pop) for (int c = 0; c < COL; c++) void'(q[c].pop_front());
    #1;
    tb_wr = '0;
    tb_rd = 1'b0;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_clear();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [BW-1:0] col0_vals [DEPTH];
    logic [W-1:0]  wd;
    logic [W-1:0]  exp_row;
    logic [W-1:0]  special;
    logic [COL-1:0] wm;

    reset = 1'b0;
    tb_in = '0;
    tb_wr = '0;
    tb_rd = 1'b0;
    model_clear();

    // Reset then idle.
    repeat (2) @(negedge clk);
    check("rst.valid", W'(tb_valid), '0);
    check("rst.full",  W'(tb_full),  '0);
    check("rst.ovf",   W'(tb_ovf),   '0);
    check("rst.out",   tb_out,       '0);
    reset = 1'b1;
    @(negedge clk);
    step('0, '0, 1'b0, "idle");

    // Skewed fill: column c written on cycle t+c with 0x0100+c.
    for (int c = 0; c < COL; c++) begin
      wd = '0;
      wd[c*BW +: BW] = BW'(16'h0100 + c);
      step(COL'(1) << c, wd, 1'b0, "skew");
      if (c < COL - 1) check("skew.valid_early", W'(tb_valid), '0);
    end
    check("skew.valid_rise", W'(tb_valid), W'(1));
    exp_row = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
    check("skew.row", tb_out, exp_row);
    step('0, '0, 1'b1, "skew_pop");
    check("skew.valid_after_pop", W'(tb_valid), '0);

    // Column 0 filled to depth, then one extra write.
    do_reset("rst2");
    for (int i = 0; i < DEPTH; i++) begin
      col0_vals[i] = BW'($urandom);
      wd = '0;
      wd[BW-1:0] = col0_vals[i];
      step(COL'(1), wd, 1'b0, "fill0");
    end
    check("fill0.full",  W'(tb_full),  W'(1));
    check("fill0.valid", W'(tb_valid), '0);
    check("fill0.ovf_before", W'(tb_ovf), '0);
    step(COL'(1), W'(16'hDEAD), 1'b0, "fill0_extra");
    check("fill0.ovf", W'(tb_ovf), W'(1));
    check("fill0.head_kept", W'(tb_out[BW-1:0]), W'(relu(col0_vals[0])));
    for (int i = 0; i < DEPTH; i++) step(~COL'(1), rand_row(), 1'b0, "fill_rest");
    for (int i = 0; i < DEPTH; i++) begin
      check("fill0.readback", W'(tb_out[BW-1:0]), W'(relu(col0_vals[i])));
      step('0, '0, 1'b1, "drain0");
    end
    check("drain0.valid", W'(tb_valid), '0);
    check("drain0.ovf_sticky", W'(tb_ovf), W'(1));

    // All columns full; read and write together on the same edge.
    do_reset("rst3");
    for (int i = 0; i < DEPTH; i++) step('1, rand_row(), 1'b0, "fill_all");
    check("full_all.full", W'(tb_full), W'(1));
    special = rand_row();
    step('1, special, 1'b1, "full_rw");
    check("full_rw.ovf",  W'(tb_ovf),  '0);
    check("full_rw.full", W'(tb_full), W'(1));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_rw.last_row", tb_out, relu_row(special));
      step('0, '0, 1'b1, "drain_all");
    end
    check("drain_all.valid", W'(tb_valid), '0);

    // Reset mid-stream with three rows buffered.
    for (int i = 0; i < 3; i++) step('1, rand_row(), 1'b0, "three_rows");
    check("three.valid", W'(tb_valid), W'(1));
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("midrst.valid", W'(tb_valid), '0);
    check("midrst.full",  W'(tb_full),  '0);
    check("midrst.ovf",   W'(tb_ovf),   '0);
    check("midrst.out",   tb_out,       '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step('0, '0, 1'b0, "after_midrst");
    check("after_midrst.valid", W'(tb_valid), '0);

    // Reads while not valid must not move any pointer.
    wd = '0;
    wd[BW-1:0] = 16'h1234;
    step(COL'(1), wd, 1'b0, "partial");
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1, "rd_invalid");
    special = rand_row();
    step('1, special, 1'b0, "one_row");
    exp_row = relu_row(special);
    exp_row[BW-1:0] = relu(16'h1234);
    check("rd_invalid.row", tb_out, exp_row);
    step('0, '0, 1'b1, "pop_one");
    check("pop_one.col0", W'(tb_out[BW-1:0]), W'(relu(special[BW-1:0])));
    check("pop_one.valid", W'(tb_valid), '0);

    // ReLU option: a negative and a positive psum.
    do_reset("rst4");
    special = rand_row();
    special[BW-1:0]    = 16'hFFF6;
    special[2*BW-1:BW] = 16'h000A;
    step('1, special, 1'b0, "relu");
`ifdef OFIFO_RELU_EN
    check("relu.neg", W'(tb_out[BW-1:0]), W'(16'h0000));
`else
    check("relu.neg", W'(tb_out[BW-1:0]), W'(16'hFFF6));
`endif
    check("relu.pos", W'(tb_out[2*BW-1:BW]), W'(16'h000A));

    // Randomized run: a write-heavy phase then a read-heavy phase.
    do_reset("rst5");
    for (int i = 0; i < 600; i++) begin
      wm = COL'($urandom);
      if ($urandom_range(3) == 0) wm = '0;
      if (i < 300) step(wm, rand_row(), ($urandom_range(4) == 0), "rand_fill");
      else         step(wm & COL'($urandom), rand_row(), ($urandom_range(4) != 0), "rand_drain");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output collection buffer directly downstream of mac_array.
- Captures each column's out_s psum when that column's valid bit pulses. Columns arrive diagonally skewed by one cycle per column.
- Realigns the columns into full rows for the SRAM write-back / SFP stage.
- One independent FIFO per column; a row is released only when every column holds at least one entry.

Parameters:
- col, 8, number of columns (matches mac_array col)
- psum_bw, 16, width of one partial sum (two's complement)
- depth, 64, entries per column FIFO; must be a power of two ≥ 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in  input  psum_bw*col  psum bus from mac_array out_s; column c at [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-column write strobe, driven by mac_array valid
- rd  input  1  pop one complete row
- out  output  psum_bw*col  head row, column c in the same slice as in
- o_valid  output  1  all columns non-empty; out is meaningful
- o_full  output  1  any column FIFO full
- o_overflow  output  1  sticky; a write was dropped

Behaviour:
- Reset asserted (reset=0, any time, asynchronous):
  - all read/write pointers cleared; o_valid=0, o_full=0, o_overflow=0
  - out=0; storage contents don't-care
  - in-flight operations are abandoned and no partial row survives.
- Pointers are log2(depth)+1 bits.
  - Empty: wptr==rptr.
  - Full: indices equal, MSBs differ.
  - Wrap-around is natural modulo 2*depth.
- Write, column c: if wr[c]=1 at a clock edge, the slice of in for column c is stored at wptr_c and wptr_c increments.
  - Columns are written independently. Any subset of wr bits may be set in a cycle.
- Read is first-word-fall-through: out always presents the head entry of every column, with zero added latency.
  - rd=1 with o_valid=1: every column's rptr increments at the edge, and the next row appears on out in the following cycle.
  - rd=1 with o_valid=0: ignored; no pointer moves.
- Simultaneous read and write on the same column: both take effect and that column's occupancy is unchanged.
  - A write to a full column is accepted if a valid pop occurs on that same edge.
- Write to a full column with no same-cycle pop: data dropped, wptr holds, o_overflow set to 1 and held until reset.
  - Other columns written in that cycle proceed normally.
- Output flags:
  - o_valid = AND over columns of non-empty. Combinational from registered pointers; no combinational path from rd or wr.
  - o_full = OR over columns of full. Same timing.
- No arithmetic on data except the optional feature below; psums pass bit-exact.

Optional Feature:
- Macro OFIFO_RELU_EN.
- Defined: each column slice of out is forced to 0 when its MSB is 1 (signed negative), otherwise passed unchanged. This is combinational on the read path; stored data stays raw.
- Undefined: out is the raw stored psum.
- Flags and pointers are identical in both builds.

Decomposition:
- Shared package holds:
  - OFIFO_PTR_W = log2(depth)+1 helper constant
  - psum slice-index helper
  - default col/psum_bw values shared with mac_array, so the array and the buffer agree.
- One natural sub-module: ofifo_col. It is a single-column synchronous FWFT FIFO (wr, rd, in, out, empty, full, overflow) with async active-low reset. ofifo instantiates col copies through a generate loop and combines the flags.

Test Plan:
- Reset then idle → o_valid=0, o_full=0, o_overflow=0, out=0. Assert reset mid-stream with 3 rows buffered → all flags 0 on the same cycle, and o_valid stays 0 after release.
- Skewed fill: col=8, pulse wr[c] at cycle t+c with column c value 16'h0100+c → o_valid rises only the cycle after wr[7]. out equals {16'h0107,…,16'h0100}, and a single rd returns o_valid to 0.
- Fill column 0 with 64 entries, others empty → o_full=1, o_valid=0. A 65th wr[0] → o_overflow=1 and the stored data is unchanged. Reading the entries back later returns the first 64 values in order.
- Fill all columns to 64 and assert rd together with wr=8'hFF on the same edge → no overflow, o_full stays 1. The new row is read last, after 64 pops.
- rd pulses while o_valid=0 → no pointer change. Verify by writing one row afterwards and reading exactly that row.
- With OFIFO_RELU_EN defined: store 16'hFFF6 (−10) and 16'h000A → out shows 0 and 000A. Without the macro → out shows FFF6 and 000A.
